// File: rtl/window_stream_gen.sv
// Raster-order pixel stream to 3x3 sliding-window generator: two line buffers
// plus short column history registers, one registered window per interior pixel.
module window_stream_gen #(
  parameter int IMG_W = 130,
  parameter int IMG_H = 130,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] pix_in,
  input  logic          pix_valid,
  output logic          pix_ready,
  output logic          win_valid,
  output logic [DW-1:0] sw_pixel_1,
  output logic [DW-1:0] sw_pixel_2,
  output logic [DW-1:0] sw_pixel_3,
  output logic [DW-1:0] sw_pixel_4,
  output logic [DW-1:0] sw_pixel_5,
  output logic [DW-1:0] sw_pixel_6,
  output logic [DW-1:0] sw_pixel_7,
  output logic [DW-1:0] sw_pixel_8,
  output logic [DW-1:0] sw_pixel_9,
  output logic          busy,
  output logic          done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          accept;
  logic          col_last;
  logic          row_last;
  logic          frame_last;
  logic          interior;

  logic [DW-1:0] lb0 [IMG_W];
  logic [DW-1:0] lb1 [IMG_W];
  logic [DW-1:0] lb0_rd;
  logic [DW-1:0] lb1_rd;

  // Columns c-2 (index 0) and c-1 (index 1); column c is the live read.
  logic [DW-1:0] top_q [2];
  logic [DW-1:0] mid_q [2];
  logic [DW-1:0] bot_q [2];

  assign accept     = pix_valid && (state == FILL);
  assign col_last   = (col == CW'(IMG_W - 1));
  assign row_last   = (row == RW'(IMG_H - 1));
  assign frame_last = accept && col_last && row_last;
  assign interior   = (row >= RW'(2)) && (col >= CW'(2));
  assign lb0_rd     = lb0[col];
  assign lb1_rd     = lb1[col];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    pix_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = FILL;
      FILL: begin
        pix_ready = 1'b1;
        busy      = 1'b1;
        if (frame_last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (state == IDLE && start) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // NOTE: line buffer RAMs are deliberately not reset; a window needs two fresh rows,
  // so nothing written before the current frame can reach the outputs.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[col] <= lb1_rd;
      lb1[col] <= pix_in;
    end
  end

  // NOTE: all state updates use non-blocking assignment so the history shift and the
  // window capture below both see the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        top_q[i] <= '0;
        mid_q[i] <= '0;
        bot_q[i] <= '0;
      end
    end else if (accept) begin
      top_q[0] <= top_q[1];
      mid_q[0] <= mid_q[1];
      bot_q[0] <= bot_q[1];
      top_q[1] <= lb0_rd;
      mid_q[1] <= lb1_rd;
      bot_q[1] <= pix_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid  <= 1'b0;
      sw_pixel_1 <= '0;
      sw_pixel_2 <= '0;
      sw_pixel_3 <= '0;
      sw_pixel_4 <= '0;
      sw_pixel_5 <= '0;
      sw_pixel_6 <= '0;
      sw_pixel_7 <= '0;
      sw_pixel_8 <= '0;
      sw_pixel_9 <= '0;
    end else begin
      win_valid <= accept && interior;
      if (accept && interior) begin
        sw_pixel_1 <= top_q[0];
        sw_pixel_2 <= top_q[1];
        sw_pixel_3 <= lb0_rd;
        sw_pixel_4 <= mid_q[0];
        sw_pixel_5 <= mid_q[1];
        sw_pixel_6 <= lb1_rd;
        sw_pixel_7 <= bot_q[0];
        sw_pixel_8 <= bot_q[1];
        sw_pixel_9 <= pix_in;
      end
    end
  end

endmodule
